muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the five-stage MIPS pipeline.
- Accepts an operation from the EXE stage and runs a 32-step shift-add multiply or restoring divide over multiple cycles.
- Writes the 64-bit result into HI/LO and raises a stall request so the hazard logic freezes PC/IR while HI/LO are not yet valid.
- Replaces the single-cycle 64-bit ALU HI/LO path with a shared, time-multiplexed arithmetic resource.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; the unit runs 2^CNT_W iterations, and this must equal WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  launch the operation in op using operands a and b.
- op  input  2  00 mult, 01 multu, 10 div, 11 divu.
- a  input  32  rs operand (multiplicand or dividend).
- b  input  32  rt operand (multiplier or divisor).
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  32  data for mthi/mtlo.
- rd_hilo  input  1  the instruction in ID/EXE reads HI or LO (mfhi/mflo).
- flush  input  1  cancel the in-flight operation.
- busy  output  1  operation in progress.
- stall_req  output  1  request pipeline freeze.
- done  output  1  one-cycle pulse: HI/LO just updated by an operation.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, done=0, count=0; busy=0 and stall_req=0. Reset takes effect immediately, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 sampled at edge N latches the magnitudes of a and b (signed ops take two's-complement absolute values), op, and sign flags, then moves to CALC with count=0.
  - If start=1 and b=0 with op=div or divu: move directly to FIX with a div-by-zero flag set; HI/LO are left unchanged and done pulses at N+2.
- CALC:
  - One iteration per cycle; count increments each cycle.
  - Multiply: 64-bit shift-add.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - At count=31, move to FIX. CALC occupies cycles N+1..N+32.
- FIX (cycle N+33):
  - Apply sign correction, write hi/lo, set done=1 for cycle N+34, and return to IDLE.
  - Signed mult: the 64-bit product is negated when the operand signs differ.
  - Signed div: the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - The result goes to lo=quotient and hi=remainder; mult gives {hi,lo}=product.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0 (wraps, no trap).
- busy = (state != IDLE), combinational.
- stall_req = busy & (start | rd_hilo | mthi | mtlo), combinational.
- start, mthi and mtlo arriving while busy are ignored; the pipeline holds and re-presents them.
- mthi/mtlo in IDLE: the register is written at the edge and visible the next cycle. If start and mthi/mtlo are asserted together in IDLE, start wins and the write is dropped.
- flush while busy: return to IDLE at the next edge, hi/lo unchanged, no done pulse. flush in IDLE has no effect. flush together with start in IDLE: start is ignored.
- done is 0 in every cycle except the one following FIX.

Test Plan:
- Multiply: mult a=0xFFFFFFFD (-3), b=5, start at cycle N. Required: busy=1 for N+1..N+33; at N+34 hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1 for exactly one cycle.
- Divide: divu 100/7 gives lo=14, hi=2. div -7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0. Each completes at N+34.
- Divide by zero: with hi=0xAAAA, lo=0x5555, issue divu 9/0. Required: done at N+2, hi/lo unchanged, busy=1 only at N+1.
- Hazards:
  - rd_hilo=1 during CALC gives stall_req=1; rd_hilo=1 in IDLE gives stall_req=0.
  - start with new operands at N+5 is ignored; the result still equals the first operation.
  - mtlo 0x1234 while busy: lo is not written.
- Cancellation: flush at N+10 gives state IDLE at N+11, busy=0, hi/lo unchanged, no done. rst=0 asserted asynchronously mid-CALC forces hi=lo=0 and busy=0 immediately.
- Direct writes in IDLE: mthi wdata=0xDEADBEEF gives hi=0xDEADBEEF next cycle with lo unchanged; start and mtlo together in IDLE gives the operation result and the mtlo write is dropped.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair: 32-step shift-add
// multiply or restoring divide, with stall requests while HI/LO are pending.
module muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_hilo,
   input  logic             flush,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
   logic               is_div, neg_q, neg_r, dz;

   logic               launch, b_zero, sa, sb;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   res_hi, res_lo;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic s);
      return s ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] x, input logic s);
      return s ? -x : x;
   endfunction

   assign launch    = (state == IDLE) && start && !flush;
   assign b_zero    = (b == '0);
   assign sa        = !op[0] && a[WIDTH-1];
   assign sb        = !op[0] && b[WIDTH-1];
   assign busy      = (state != IDLE);
   assign stall_req = busy && (start || rd_hilo || mthi || mtlo);

   // Iteration datapath: multiply adds into the upper half then shifts right;
   // divide shifts the dividend into the remainder and subtracts when it fits.
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};

   assign prod   = {acc_hi, acc_lo};
   assign prod_s = neg_if2(prod, neg_q);
   assign res_hi = is_div ? neg_if(acc_hi, neg_r) : prod_s[2*WIDTH-1:WIDTH];
   assign res_lo = is_div ? neg_if(acc_lo, neg_q) : prod_s[WIDTH-1:0];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (launch) state_nx = (op[1] && b_zero) ? FIX : CALC;
         CALC: begin
            if (flush)       state_nx = IDLE;
            else if (&count) state_nx = FIX;
         end
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nx;
         count <= (state == CALC) ? count + 1'b1 : '0;
         done  <= (state == FIX) && !flush;
         if (state == FIX && !flush && !dz) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE && !launch) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
      end
   end

   // Operand latch and per-iteration update; no reset needed on pure data.
   always_ff @(posedge clk) begin
      if (launch) begin
         acc_hi <= '0;
         acc_lo <= op[1] ? neg_if(a, sa) : neg_if(b, sb);
         opnd   <= op[1] ? neg_if(b, sb) : neg_if(a, sa);
         is_div <= op[1];
         neg_q  <= sa ^ sb;
         neg_r  <= sa;
         dz     <= op[1] && b_zero;
      end else if (state == CALC) begin
         if (is_div) begin
            if (!div_diff[WIDTH]) begin
               acc_hi <= div_diff[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= div_shift[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results, div-by-zero, hazards,
// flush, asynchronous reset and direct HI/LO writes.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, mthi, mtlo, rd_hilo, flush;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, stall_req, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic seen_done;

   muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hilo(rd_hilo), .flush(flush),
      .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents start in cycle N and checks the full N+1..N+35 timeline.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic with_mtlo);
      op = o; a = x; b = y; start = 1'b1; mtlo = with_mtlo; wdata = 32'h1234;
      step();
      start = 1'b0; mtlo = 1'b0;
      chk({tag, "_busy_n1"}, busy, 1);
      repeat (32) step();
      chk({tag, "_busy_n33"}, busy, 1);
      chk({tag, "_done_n33"}, done, 0);
      step();
      chk({tag, "_done_n34"}, done, 1);
      chk({tag, "_busy_n34"}, busy, 0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      step();
      chk({tag, "_done_n35"}, done, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_hilo = 1'b0;
      flush = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
      #12;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall_req, 0);
      rst = 1'b1;
      step();

      do_op("mult", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      do_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      do_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
      do_op("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

      // Direct writes, then divide by zero
      mthi = 1'b1; wdata = 32'hAAAA; step(); mthi = 1'b0;
      chk("mthi_aaaa", hi, 32'hAAAA);
      mtlo = 1'b1; wdata = 32'h5555; step(); mtlo = 1'b0;
      chk("mtlo_5555", lo, 32'h5555);
      chk("mtlo_hi_kept", hi, 32'hAAAA);
      op = 2'b11; a = 32'd9; b = 32'd0; start = 1'b1;
      step(); start = 1'b0;
      chk("dz_busy_n1", busy, 1);
      chk("dz_done_n1", done, 0);
      step();
      chk("dz_done_n2", done, 1);
      chk("dz_busy_n2", busy, 0);
      chk("dz_hi", hi, 32'hAAAA);
      chk("dz_lo", lo, 32'h5555);
      step();
      chk("dz_done_n3", done, 0);

      mthi = 1'b1; wdata = 32'hDEADBEEF; step(); mthi = 1'b0;
      chk("mthi_dead", hi, 32'hDEADBEEF);
      chk("mthi_lo_kept", lo, 32'h5555);

      // Hazards: rd_hilo in IDLE, then during CALC with a second start and mtlo
      rd_hilo = 1'b1; #1;
      chk("stall_idle", stall_req, 0);
      rd_hilo = 1'b0;
      op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
      step(); start = 1'b0;
      repeat (3) step();
      rd_hilo = 1'b1; #1;
      chk("stall_rd_calc", stall_req, 1);
      rd_hilo = 1'b0;
      step();
      op = 2'b10; a = 32'd100; b = 32'd3; start = 1'b1; #1;
      chk("stall_start_calc", stall_req, 1);
      step(); start = 1'b0;
      mtlo = 1'b1; wdata = 32'h1234;
      step(); mtlo = 1'b0;
      repeat (27) step();
      chk("haz_done", done, 1);
      chk("haz_hi", hi, 32'd0);
      chk("haz_lo", lo, 32'd42);
      step();

      // Flush at N+10
      op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
      step(); start = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step(); flush = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_hi", hi, 32'd0);
      chk("flush_lo", lo, 32'd42);
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         seen_done = seen_done | done;
      end
      chk("flush_no_done", seen_done, 0);
      chk("flush_lo_later", lo, 32'd42);

      // start and mtlo together in IDLE: operation wins
      do_op("mt_start", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);

      // Asynchronous reset mid-CALC
      op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
      step(); start = 1'b0;
      repeat (4) step();
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      step();
      rst = 1'b1;
      step();
      chk("arst_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
